// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported variable-latency memory between the fetch (I) and memory-stage (D) ports.
// Fixed D priority with a streak-based starvation guard, misalignment and timeout errors, and a halt/quiesce path.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    output logic        quiesced
);

    localparam int StreakW = $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);
    localparam logic [7:0] ToLimit = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arbState;

    arbState            state, stateNxt;
    logic [StreakW-1:0] streak, streakNxt;
    logic [7:0]         toCnt, toCntNxt;
    logic               dWins;

    logic        memReqNxt, memWrNxt;
    logic [15:0] memAddrNxt, memWdataNxt;
    logic        iDoneNxt, iErrNxt, dDoneNxt, dErrNxt, quiescedNxt;
    logic [15:0] iRdataNxt, dRdataNxt;

    always_comb begin
        stateNxt    = state;
        streakNxt   = streak;
        toCntNxt    = toCnt;
        memReqNxt   = 1'b0;
        memWrNxt    = mem_wr;
        memAddrNxt  = mem_addr;
        memWdataNxt = mem_wdata;
        iDoneNxt    = 1'b0;
        iErrNxt     = 1'b0;
        iRdataNxt   = '0;
        dDoneNxt    = 1'b0;
        dErrNxt     = 1'b0;
        dRdataNxt   = '0;
        quiescedNxt = (state == IDLE) && halt;
        // D normally wins; a full streak with I waiting hands the grant to I
        dWins       = d_req && !(i_req && (streak == StreakMax));

        unique case (state)
            IDLE: begin
                if (!halt) begin
                    if (dWins) begin
                        if (!i_req)
                            streakNxt = '0;
                        else if (streak != StreakMax)
                            streakNxt = streak + 1'b1;
                        if (d_addr[0]) begin
                            dDoneNxt = 1'b1;
                            dErrNxt  = 1'b1;
                        end else begin
                            stateNxt    = BUSY_D;
                            memReqNxt   = 1'b1;
                            memWrNxt    = d_wr;
                            memAddrNxt  = d_addr;
                            memWdataNxt = d_wdata;
                            toCntNxt    = 8'd1;
                        end
                    end else if (i_req) begin
                        streakNxt = '0;
                        if (i_addr[0]) begin
                            iDoneNxt = 1'b1;
                            iErrNxt  = 1'b1;
                        end else begin
                            stateNxt    = BUSY_I;
                            memReqNxt   = 1'b1;
                            memWrNxt    = 1'b0;
                            memAddrNxt  = i_addr;
                            memWdataNxt = '0;
                            toCntNxt    = 8'd1;
                        end
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // mem_done is ignored during the strobe cycle itself; success beats a same-cycle timeout
                if (!mem_req && mem_done) begin
                    stateNxt = IDLE;
                    toCntNxt = '0;
                    if (state == BUSY_I) begin
                        iDoneNxt  = 1'b1;
                        iRdataNxt = mem_rdata;
                    end else begin
                        dDoneNxt  = 1'b1;
                        dRdataNxt = mem_wr ? '0 : mem_rdata;
                    end
                end else if (toCnt == ToLimit) begin
                    stateNxt = IDLE;
                    toCntNxt = '0;
                    if (state == BUSY_I) begin
                        iDoneNxt = 1'b1;
                        iErrNxt  = 1'b1;
                    end else begin
                        dDoneNxt = 1'b1;
                        dErrNxt  = 1'b1;
                    end
                end else begin
                    toCntNxt = toCnt + 8'd1;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            toCnt     <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            quiesced  <= 1'b0;
        end else begin
            state     <= stateNxt;
            streak    <= streakNxt;
            toCnt     <= toCntNxt;
            mem_req   <= memReqNxt;
            mem_wr    <= memWrNxt;
            mem_addr  <= memAddrNxt;
            mem_wdata <= memWdataNxt;
            i_done    <= iDoneNxt;
            i_err     <= iErrNxt;
            i_rdata   <= iRdataNxt;
            d_done    <= dDoneNxt;
            d_err     <= dErrNxt;
            d_rdata   <= dRdataNxt;
            quiesced  <= quiescedNxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: requesters push expected responses, a negedge monitor pops and compares.
// Memory latency and data come from per-address tables, so every expected response follows from the address alone.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, halt;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, i_err, d_done, d_err;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_req, mem_wr, mem_done;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        quiesced;
    logic        memDoneResp, memDoneInj;

    assign mem_done = memDoneResp | memDoneInj;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .halt(halt), .quiesced(quiesced)
    );

    int total = 0;
    int bad = 0;
    int iDoneCnt = 0;
    int dDoneCnt = 0;
    int memReqCnt = 0;
    logic [3:0]  latTab [256];
    logic [15:0] dataTab[256];
    logic [16:0] iQ[$];
    logic [16:0] dQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event want event within bound", name);
    endtask

    // Latency 0 never answers and 15 answers too late: both are timeouts; 14 is the last success.
    function automatic logic [16:0] expResp(input logic [15:0] a, input logic wr);
        logic [7:0] k;
        k = a[8:1];
        if (a[0]) return 17'h10000;
        if (latTab[k] == 4'd0 || latTab[k] == 4'd15) return 17'h10000;
        return {1'b0, wr ? 16'h0000 : dataTab[k]};
    endfunction

    task automatic waitFor(input int which, input int maxCyc, output int cyc);
        logic hit;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            hit = (which == 0) ? i_done : (which == 1) ? d_done : mem_req;
            if (hit) return;
            if (cyc >= maxCyc) begin
                fail($sformatf("wait_%0d", which));
                return;
            end
        end
    endtask

    // memory model: mem_done rises latTab[addr] cycles after the mem_req cycle
    initial begin
        int respCnt;
        logic [15:0] respAddr;
        respCnt = 0;
        respAddr = '0;
        memDoneResp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            memDoneResp = 1'b0;
            mem_rdata = 16'($urandom);
            if (respCnt > 0) begin
                respCnt--;
                if (respCnt == 0) begin
                    memDoneResp = 1'b1;
                    mem_rdata = dataTab[respAddr[8:1]];
                end
            end
            if (mem_req) begin
                respAddr = mem_addr;
                respCnt = int'(latTab[mem_addr[8:1]]);
            end
        end
    end

    initial begin
        logic prevMemReq;
        logic okI, okD;
        logic [16:0] e;
        prevMemReq = 1'b0;
        forever begin
            @(negedge clk);
            if (i_done || d_done) check("done_exclusive", 32'(i_done && d_done), 0);
            if (i_done) begin
                iDoneCnt++;
                check("i_expected_pending", 32'(iQ.size() > 0), 1);
                if (iQ.size() > 0) begin
                    e = iQ.pop_front();
                    check("i_resp", 32'({i_err, i_rdata}), 32'(e));
                end
            end
            if (d_done) begin
                dDoneCnt++;
                check("d_expected_pending", 32'(dQ.size() > 0), 1);
                if (dQ.size() > 0) begin
                    e = dQ.pop_front();
                    check("d_resp", 32'({d_err, d_rdata}), 32'(e));
                end
            end
            if (mem_req) begin
                memReqCnt++;
                okI = i_req && !mem_wr && (mem_addr == i_addr);
                okD = d_req && (mem_wr == d_wr) && (mem_addr == d_addr) && (!d_wr || mem_wdata == d_wdata);
                check("mem_align", 32'(mem_addr[0]), 0);
                check("mem_req_matches_request", 32'(okI || okD), 1);
                check("mem_req_single_cycle", 32'(prevMemReq), 0);
            end
            prevMemReq = mem_req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        int cyc, n, dn, dCount, r;
        logic [15:0] a;
        logic [3:0] lat;
        rst = 1'b0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        halt = 0; memDoneInj = 0;
        for (int k = 0; k < 256; k++) begin
            latTab[k] = 4'd1;
            dataTab[k] = 16'($urandom);
        end
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(|{i_done, i_err, i_rdata, d_done, d_err, d_rdata,
                                    mem_req, mem_wr, mem_addr, mem_wdata, quiesced}), 0);
        rst = 1'b1;

        // single I read
        latTab[8'h08] = 4'd2;
        dataTab[8'h08] = 16'hA5A5;
        i_addr = 16'h0010; i_req = 1;
        iQ.push_back(expResp(16'h0010, 1'b0));
        waitFor(2, 5, cyc);
        check("t1_memreq_latency", 32'(cyc), 1);
        check("t1_mem_addr", 32'(mem_addr), 32'h10);
        check("t1_mem_wr", 32'(mem_wr), 0);
        waitFor(0, 20, cyc);
        check("t1_done_latency", 32'(cyc), 3);
        check("t1_rdata", 32'(i_rdata), 32'hA5A5);
        i_req = 0;

        // simultaneous requests: D first
        latTab[8'h10] = 4'd1; latTab[8'h20] = 4'd1;
        d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        dQ.push_back(expResp(16'h0020, 1'b1));
        i_req = 1; i_addr = 16'h0040;
        iQ.push_back(expResp(16'h0040, 1'b0));
        waitFor(2, 5, cyc);
        check("t2_first_wr", 32'(mem_wr), 1);
        check("t2_first_wdata", 32'(mem_wdata), 32'h1234);
        check("t2_first_addr", 32'(mem_addr), 32'h20);
        n = iDoneCnt;
        waitFor(1, 20, cyc);
        check("t2_i_not_before_d", 32'(iDoneCnt), 32'(n));
        d_req = 0; d_wr = 0;
        waitFor(2, 5, cyc);
        check("t2_second_addr", 32'(mem_addr), 32'h40);
        check("t2_second_wr", 32'(mem_wr), 0);
        waitFor(0, 20, cyc);
        i_req = 0;

        // starvation guard, two rounds to show the streak restarts after an I grant
        for (int k = 8'h28; k < 8'h40; k++) latTab[k] = 4'd1;
        dn = 0;
        for (int round = 0; round < 2; round++) begin
            i_req = 1; i_addr = 16'h0050;
            iQ.push_back(expResp(16'h0050, 1'b0));
            if (round == 0) begin
                d_req = 1; d_wr = 0; d_addr = 16'h0060 + 16'(2 * dn); dn++;
                dQ.push_back(expResp(d_addr, 1'b0));
            end
            dCount = 0;
            cyc = 0;
            while (1) begin
                @(negedge clk);
                cyc++;
                if (d_done) begin
                    dCount++;
                    d_addr = 16'h0060 + 16'(2 * dn); dn++;
                    dQ.push_back(expResp(d_addr, 1'b0));
                end
                if (i_done) break;
                if (cyc > 200) begin
                    fail("t3_i_grant");
                    break;
                end
            end
            check("t3_d_grants_before_i", 32'(dCount), 4);
            i_req = 0;
        end
        waitFor(1, 20, cyc);
        d_req = 0;

        // misaligned D access
        d_req = 1; d_wr = 0; d_addr = 16'h0031;
        dQ.push_back(expResp(16'h0031, 1'b0));
        n = memReqCnt;
        waitFor(1, 5, cyc);
        check("t4_done_latency", 32'(cyc), 1);
        check("t4_err", 32'(d_err), 1);
        d_req = 0;
        @(negedge clk);
        check("t4_no_mem_req", 32'(memReqCnt), 32'(n));

        // timeout with a late mem_done injected afterwards
        latTab[8'h38] = 4'd0;
        i_req = 1; i_addr = 16'h0070;
        iQ.push_back(expResp(16'h0070, 1'b0));
        waitFor(2, 5, cyc);
        waitFor(0, 40, cyc);
        check("t5_timeout_cycles", 32'(cyc), 15);
        i_req = 0;
        n = iDoneCnt + dDoneCnt;
        r = memReqCnt;
        repeat (2) @(negedge clk);
        memDoneInj = 1;
        @(negedge clk);
        memDoneInj = 0;
        repeat (3) @(negedge clk);
        check("t5_late_done_ignored", 32'(iDoneCnt + dDoneCnt), 32'(n));
        check("t5_no_new_req", 32'(memReqCnt), 32'(r));

        // mem_done right at the limit succeeds, one cycle later is a timeout
        for (int k = 0; k < 2; k++) begin
            a = 16'h0072 + 16'(2 * k);
            latTab[a[8:1]] = (k == 0) ? 4'd14 : 4'd15;
            i_req = 1; i_addr = a;
            iQ.push_back(expResp(a, 1'b0));
            waitFor(2, 5, cyc);
            waitFor(0, 40, cyc);
            check("t5_limit_cycles", 32'(cyc), 15);
            check("t5_limit_err", 32'(i_err), 32'(k));
            i_req = 0;
            @(negedge clk);
        end

        // randomized traffic on both ports
        for (int k = 0; k < 256; k++) begin
            r = int'($urandom_range(0, 9));
            lat = (r <= 6) ? 4'(1 + r % 4) : (r == 7) ? 4'd14 : (r == 8) ? 4'd15 : 4'd0;
            latTab[k] = lat;
            dataTab[k] = 16'($urandom);
        end
        fork
            begin
                int c;
                logic [15:0] ia;
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    ia = 16'($urandom);
                    ia[0] = ($urandom_range(0, 7) == 0);
                    i_addr = ia; i_req = 1;
                    iQ.push_back(expResp(ia, 1'b0));
                    waitFor(0, 300, c);
                    i_req = 0;
                end
            end
            begin
                int c;
                logic [15:0] da;
                logic w;
                for (int j = 0; j < 40; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    da = 16'($urandom);
                    da[0] = ($urandom_range(0, 7) == 0);
                    w = 1'($urandom);
                    d_addr = da; d_wr = w; d_wdata = 16'($urandom); d_req = 1;
                    dQ.push_back(expResp(da, w));
                    waitFor(1, 300, c);
                    d_req = 0;
                end
            end
        join
        repeat (2) @(negedge clk);

        // halt mid-access, then reset during a fresh access
        latTab[8'h40] = 4'd3; latTab[8'h48] = 4'd3;
        d_req = 1; d_wr = 0; d_addr = 16'h0080;
        dQ.push_back(expResp(16'h0080, 1'b0));
        waitFor(2, 5, cyc);
        halt = 1;
        i_req = 1; i_addr = 16'h0090;
        waitFor(1, 20, cyc);
        check("t6_done_under_halt", 32'(d_done), 1);
        check("t6_quiesced_in_done_cycle", 32'(quiesced), 0);
        d_req = 0;
        n = memReqCnt;
        repeat (3) begin
            @(negedge clk);
            check("t6_quiesced", 32'(quiesced), 1);
        end
        check("t6_no_grant_while_halted", 32'(memReqCnt), 32'(n));
        halt = 0;
        @(negedge clk);
        check("t6_quiesced_drops", 32'(quiesced), 0);
        check("t6_resume_req", 32'(mem_req), 1);
        check("t6_resume_addr", 32'(mem_addr), 32'h90);
        #1;
        rst = 0;
        i_req = 0;
        @(negedge clk);
        check("t6_reset_outputs", 32'(|{i_done, i_err, i_rdata, d_done, d_err, d_rdata,
                                       mem_req, mem_wr, mem_addr, mem_wdata, quiesced}), 0);
        rst = 1;
        n = iDoneCnt + dDoneCnt;
        r = memReqCnt;
        repeat (6) @(negedge clk);
        check("t6_no_done_after_reset", 32'(iDoneCnt + dDoneCnt), 32'(n));
        check("t6_no_req_after_reset", 32'(memReqCnt), 32'(r));

        check("i_queue_drained", 32'(iQ.size()), 0);
        check("d_queue_drained", 32'(dQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
